flash_cmd_arbiter: RTL
======================

FLASH_CMD_ARBITER -- requirements
Module: flash_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd12000000, giving the max WAIT duration in clk cycles (0.5 s at 24 MHz).
REQ-002 SHALL have port clk, input, 1, the single 24 MHz clock; all logic is on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 3, per-requester level request: bit0 MCU, bit1 FPGA download, bit2 log write.
REQ-005 SHALL have ports req_cmd0, req_cmd1, req_cmd2, each input, 32, the requester command: [31:24] opcode, [23:16] parameter, [15:0] data.
REQ-006 SHALL have port gnt, output, 3, one-hot grant, held from ARB exit until DONE exit.
REQ-007 SHALL have port cmd, output, 32, the latched command to the flash controller.
REQ-008 SHALL have port start_trs, output, 1, a one-cycle command strobe.
REQ-009 SHALL have ports end_read, end_write and end_erase, each input, 1, completion pulses from the flash controller.
REQ-010 SHALL have port flash_cmd_incomplete, input, 1, a controller abort pulse.
REQ-011 SHALL have port done, output, 3, a one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err, output, 2, the status valid with done: 0 ok, 1 incomplete, 2 timeout, 3 bad opcode.
REQ-013 SHALL have port arb_busy, output, 1, which is high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, ARB, ISSUE, WAIT and DONE.
REQ-015 IDLE SHALL move to ARB on the first cycle that req is non-zero.
REQ-016 ARB SHALL grant round-robin, starting the search at the index after last_gnt, wrapping 2->0, and SHALL latch that requester's req_cmd into cmd and set gnt.
REQ-017 ARB SHALL decode the opcode: 8'hA1 is read, 8'hA2 write, 8'hA3 erase.
REQ-018 On any other opcode, ARB SHALL go directly to DONE with err=3 and SHALL NOT assert start_trs.
REQ-019 ISSUE SHALL assert start_trs for exactly one cycle, then go to WAIT; latency from req rising in IDLE to start_trs is 2 cycles.
REQ-020 WAIT SHALL exit to DONE only on the end_* pulse matching the latched opcode class; non-matching end_* pulses are ignored.
REQ-021 flash_cmd_incomplete in WAIT SHALL exit to DONE with err=1.
REQ-022 If a matching end_* and flash_cmd_incomplete occur in the same cycle, completion SHALL win with err=0.
REQ-023 DONE SHALL pulse done[granted] for one cycle, update last_gnt, clear gnt, and return to IDLE.
REQ-024 After DONE, one IDLE cycle SHALL elapse before the next ARB.
REQ-025 Deasserting req after grant SHALL NOT cancel the command; req asserted while arb_busy is held pending.
REQ-026 cmd SHALL hold its latched value until the next ARB; it is not cleared in IDLE.
REQ-027 start_trs SHALL never be asserted outside ISSUE.

Reset
REQ-028 On rst low, asynchronously: state=IDLE; gnt, cmd, start_trs, done, err and arb_busy all 0; last_gnt=2, so that req0 wins the first arbitration.
REQ-029 Reset mid-WAIT SHALL abandon the command without a done pulse; later end_* pulses in IDLE are ignored.

Configuration
REQ-030 With macro FLASH_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-031 With FLASH_ARB_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES-1 SHALL force DONE with err=2.
REQ-032 With FLASH_ARB_TIMEOUT_EN defined, a matching end_* in the same cycle as the timeout SHALL win with err=0.
REQ-033 Without FLASH_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL be unbounded, and err=2 SHALL never be produced.

Verification
REQ-034 Bench SHALL cover: req=3'b001, req_cmd0=32'hA1_00_1234, end_read 5 cycles after start_trs -> start_trs 2 cycles after req, cmd=32'hA1001234, done=3'b001 with err=0.
REQ-035 Bench SHALL cover: req=3'b111 held through three complete transactions -> grant order 0, 1, 2, each done before the next start_trs.
REQ-036 Bench SHALL cover: req_cmd1=32'h55000000 granted -> done=3'b010 with err=3, and no start_trs pulse.
REQ-037 Bench SHALL cover: write (8'hA2) in WAIT with end_read pulsed, then flash_cmd_incomplete -> end_read ignored, err=1.
REQ-038 Bench SHALL cover: FLASH_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no end_* pulse -> done with err=2 exactly 16 cycles after WAIT entry.
REQ-039 Bench SHALL cover: rst low 3 cycles after start_trs -> all outputs 0 immediately, no done pulse, next req0 granted first.

Source files
------------

// File: rtl/flash_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// flash_cmd_arbiter
//
// Shares one flash controller between three requesters (MCU, FPGA download,
// log write). A round-robin arbiter picks one requester, latches its command,
// strobes it to the controller, waits for the completion pulse matching the
// command class, then returns a one-cycle done pulse with a status code.
//
// Optional build macro: FLASH_ARB_TIMEOUT_EN
//   When defined, a 24-bit counter bounds the WAIT state to TIMEOUT_CYCLES
//   clocks and reports err=2 on expiry. When undefined, WAIT is unbounded.
//
// Ports
//   clk                  : 24 MHz clock, all logic on the rising edge
//   rst                  : asynchronous active-low reset
//   req[2:0]             : level requests (0 MCU, 1 FPGA download, 2 log write)
//   req_cmd0..2[31:0]    : per-requester command {opcode, parameter, data}
//   gnt[2:0]             : one-hot grant, held from ARB exit until DONE exit
//   cmd[31:0]            : latched command to the flash controller
//   start_trs            : one-cycle command strobe (ISSUE only)
//   end_read/_write/_erase : completion pulses from the controller
//   flash_cmd_incomplete : controller abort pulse
//   done[2:0]            : one-cycle completion pulse to the granted requester
//   err[1:0]             : status valid with done (0 ok, 1 incomplete,
//                          2 timeout, 3 bad opcode)
//   arb_busy             : high in every state except IDLE
// -----------------------------------------------------------------------------
module flash_cmd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [31:0] req_cmd0,
  input  logic [31:0] req_cmd1,
  input  logic [31:0] req_cmd2,
  output logic [2:0]  gnt,
  output logic [31:0] cmd,
  output logic        start_trs,
  input  logic        end_read,
  input  logic        end_write,
  input  logic        end_erase,
  input  logic        flash_cmd_incomplete,
  output logic [2:0]  done,
  output logic [1:0]  err,
  output logic        arb_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CLS_READ  = 2'd0;
  localparam logic [1:0] CLS_WRITE = 2'd1;
  localparam logic [1:0] CLS_ERASE = 2'd2;
  localparam logic [1:0] CLS_BAD   = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_INCOMPL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADOP   = 2'd3;

  state_t      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [31:0] cmd_q, cmd_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  cls_q, cls_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  req_snap_q, req_snap_d;

  logic [1:0]  win_idx;
  logic [31:0] win_cmd;
  logic [1:0]  win_cls;
  logic        match_end;
  logic        tmo_hit;

  // Round-robin pick: search starts at the index after the last grant and
  // wraps 2->0. The caller guarantees at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] first, second, third;
    case (last)
      2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (r[first])       rr_pick = first;
    else if (r[second]) rr_pick = second;
    else                rr_pick = third;
  endfunction

  function automatic logic [1:0] op_class(input logic [7:0] op);
    case (op)
      8'hA1:   op_class = CLS_READ;
      8'hA2:   op_class = CLS_WRITE;
      8'hA3:   op_class = CLS_ERASE;
      default: op_class = CLS_BAD;
    endcase
  endfunction

  // Arbitration runs on the request snapshot taken when IDLE was left, so a
  // requester dropping req during the ARB cycle cannot produce an empty grant.
  always_comb begin
    win_idx = rr_pick(req_snap_q, last_q);
    case (win_idx)
      2'd0:    win_cmd = req_cmd0;
      2'd1:    win_cmd = req_cmd1;
      default: win_cmd = req_cmd2;
    endcase
    win_cls = op_class(win_cmd[31:24]);
  end

  // Only the completion pulse of the latched command class ends WAIT.
  assign match_end = ((cls_q == CLS_READ)  && end_read)  ||
                     ((cls_q == CLS_WRITE) && end_write) ||
                     ((cls_q == CLS_ERASE) && end_erase);

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;

  // Cleared during ISSUE so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 24'd0;
    end else if (state_q == S_ISSUE) begin
      tmo_cnt_q <= 24'd0;
    end else if (state_q == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 24'd1;
    end
  end

  assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);
`else
  logic unused_timeout_param;

  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign tmo_hit              = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    err_d      = err_q;
    cls_d      = cls_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    req_snap_d = req_snap_q;
    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          req_snap_d = req;
          state_d    = S_ARB;
        end
      end
      S_ARB: begin
        gidx_d = win_idx;
        gnt_d  = 3'b001 << win_idx;
        cmd_d  = win_cmd;
        cls_d  = win_cls;
        if (win_cls == CLS_BAD) begin
          err_d   = ERR_BADOP;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion outranks both abort and timeout in the same cycle.
        if (match_end) begin
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (flash_cmd_incomplete) begin
          err_d   = ERR_INCOMPL;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = gidx_q;
        gnt_d   = 3'b000;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // last_q resets to 2 so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 3'b000;
      cmd_q      <= 32'd0;
      err_q      <= ERR_OK;
      cls_q      <= CLS_READ;
      gidx_q     <= 2'd0;
      last_q     <= 2'd2;
      req_snap_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      cls_q      <= cls_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      req_snap_q <= req_snap_d;
    end
  end

  assign gnt       = gnt_q;
  assign cmd       = cmd_q;
  assign err       = err_q;
  assign start_trs = (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE) ? gnt_q : 3'b000;
  assign arb_busy  = (state_q != S_IDLE);

endmodule
